// File: rtl/chan_fifo_writer.sv
// Packs decimated RX samples into in-band channel FIFO packets (header, timestamp, payload)
// through a ping-pong sample buffer: one bank fills while the other drains.
module chan_fifo_writer #(
  parameter int PAYLOAD_WORDS = 126,
  parameter int ADDR_W        = 7
) (
  input  logic        rx_clock,
  input  logic        reset,
  input  logic        rx_enable,
  input  logic        rx_strobe,
  input  logic [15:0] rx_i,
  input  logic [15:0] rx_q,
  input  logic [31:0] timestamp_clock,
  input  logic [7:0]  fifo_space,
  output logic        wrreq,
  output logic [31:0] fifodata,
  output logic        pkt_done,
  output logic        overrun,
  output logic [14:0] debug
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAITSPACE = 3'd1,
    S_HEADER    = 3'd2,
    S_TIMESTAMP = 3'd3,
    S_PAYLOAD   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [6:0] PW    = 7'(PAYLOAD_WORDS);
  localparam int         DEPTH = 2 ** (ADDR_W + 1);

  state_t            state_q;
  logic              en_q, fill_bank_q, drain_bank_q, sob_next_q, overrun_q;
  logic [1:0]        pend_q, sob_q, eob_q;
  logic [6:0]        count_q, pay_cnt_q;
  logic [1:0][6:0]   len_q;
  logic [1:0][31:0]  ts_q;
  logic              wrreq_q, pkt_done_q;
  logic [31:0]       fifodata_q, rdata_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [31:0]       mem_q [0:DEPTH-1];

  logic        fall_s, rise_s, take_s, blocked_s, drop_s, wr_s, mark_s;
  logic        hdr_load_s, space_ok_s;
  logic [6:0]  cnt_inc_s, drain_len_s;
  logic [1:0]  pend_set_s, pend_clr_s;
  logic [31:0] header_s;
  logic [1:0]  pend_d;
  logic        fill_bank_d, overrun_d, sob_next_d;
  logic [6:0]  count_d;

  always_comb begin
    fall_s      = en_q & ~rx_enable;
    rise_s      = ~en_q & rx_enable;
    // A strobe on the falling-enable cycle still belongs to the burst.
    take_s      = rx_strobe & (rx_enable | en_q);
    blocked_s   = pend_q[fill_bank_q];
    drop_s      = take_s & blocked_s;
    wr_s        = take_s & ~blocked_s;
    cnt_inc_s   = count_q + {6'd0, wr_s};
    mark_s      = ~blocked_s & (fall_s | (wr_s & (cnt_inc_s == PW)));
    pend_set_s  = mark_s ? (2'b01 << fill_bank_q) : 2'b00;
    pend_clr_s  = (state_q == S_DONE) ? (2'b01 << drain_bank_q) : 2'b00;
    pend_d      = (pend_q | pend_set_s) & ~pend_clr_s;
    // Move to the other bank whenever ours is pending and the other is (or is just becoming) free.
    fill_bank_d = (pend_d[fill_bank_q] & ~pend_d[~fill_bank_q]) ? ~fill_bank_q : fill_bank_q;
    count_d     = mark_s ? 7'd0 : cnt_inc_s;
    sob_next_d  = rise_s ? 1'b1 : (mark_s ? 1'b0 : sob_next_q);
    drain_len_s = len_q[drain_bank_q];
    space_ok_s  = {1'b0, fifo_space} >= ({2'b00, drain_len_s} + 9'd2);
    hdr_load_s  = (state_q == S_WAITSPACE) & space_ok_s;
    overrun_d   = drop_s ? 1'b1 : (hdr_load_s ? 1'b0 : overrun_q);
    header_s    = {overrun_q, 2'b00, sob_q[drain_bank_q], eob_q[drain_bank_q],
                   18'd0, drain_len_s, 2'b00};
  end

  always_ff @(posedge rx_clock) begin
    if (wr_s) begin
      mem_q[{fill_bank_q, count_q[ADDR_W-1:0]}] <= {rx_q, rx_i};
    end
    rdata_q <= mem_q[{drain_bank_q, rd_ptr_q}];
  end

  always_ff @(posedge rx_clock) begin
    if (reset) begin
      en_q        <= 1'b0;
      pend_q      <= 2'b00;
      fill_bank_q <= 1'b0;
      count_q     <= 7'd0;
      sob_next_q  <= 1'b0;
      overrun_q   <= 1'b0;
      len_q       <= '0;
      ts_q        <= '0;
      sob_q       <= 2'b00;
      eob_q       <= 2'b00;
    end else begin
      en_q        <= rx_enable;
      pend_q      <= pend_d;
      fill_bank_q <= fill_bank_d;
      count_q     <= count_d;
      sob_next_q  <= sob_next_d;
      overrun_q   <= overrun_d;
      // First sample of a bank, or a zero-length flush, stamps the packet.
      if ((wr_s | mark_s) && (count_q == 7'd0)) begin
        ts_q[fill_bank_q] <= timestamp_clock;
      end
      if (mark_s) begin
        len_q[fill_bank_q] <= cnt_inc_s;
        sob_q[fill_bank_q] <= sob_next_q | rise_s;
        eob_q[fill_bank_q] <= fall_s;
      end else if (fall_s & blocked_s) begin
        eob_q[fill_bank_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge rx_clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      drain_bank_q <= 1'b0;
      wrreq_q      <= 1'b0;
      fifodata_q   <= 32'd0;
      pkt_done_q   <= 1'b0;
      rd_ptr_q     <= '0;
      pay_cnt_q    <= 7'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wrreq_q    <= 1'b0;
          pkt_done_q <= 1'b0;
          if (pend_q != 2'b00) begin
            drain_bank_q <= pend_q[~fill_bank_q] ? ~fill_bank_q : fill_bank_q;
            state_q      <= S_WAITSPACE;
          end
        end
        S_WAITSPACE: begin
          if (space_ok_s) begin
            wrreq_q    <= 1'b1;
            fifodata_q <= header_s;
            rd_ptr_q   <= '0;
            state_q    <= S_HEADER;
          end
        end
        S_HEADER: begin
          fifodata_q <= ts_q[drain_bank_q];
          rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
          state_q    <= S_TIMESTAMP;
        end
        S_TIMESTAMP: begin
          rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
          if (drain_len_s == 7'd0) begin
            wrreq_q    <= 1'b0;
            pkt_done_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            fifodata_q <= rdata_q;
            pay_cnt_q  <= 7'd1;
            state_q    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (pay_cnt_q == drain_len_s) begin
            wrreq_q    <= 1'b0;
            pkt_done_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            fifodata_q <= rdata_q;
            pay_cnt_q  <= pay_cnt_q + 7'd1;
            rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
          end
        end
        S_DONE: begin
          wrreq_q    <= 1'b0;
          pkt_done_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          wrreq_q    <= 1'b0;
          pkt_done_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign wrreq    = wrreq_q;
  assign fifodata = fifodata_q;
  assign pkt_done = pkt_done_q;
  assign overrun  = overrun_q;
  assign debug    = {5'd0, state_q, fill_bank_q, pend_q, wrreq_q, rx_strobe, rx_enable, overrun_q};

endmodule

// File: tb/tb_chan_fifo_writer.sv
// Bench for chan_fifo_writer: directed packet tables, hand-written corner sequences and
// randomized bursts checked against a queue-based packet model.
module tb_chan_fifo_writer;

  localparam int PW = 4;

  logic        clk = 1'b0;
  logic        reset, rx_enable, rx_strobe;
  logic [15:0] rx_i, rx_q;
  logic [31:0] timestamp_clock;
  logic [7:0]  fifo_space;
  logic        wrreq, pkt_done, overrun;
  logic [31:0] fifodata;
  logic [14:0] debug;

  always #5 clk = ~clk;

  chan_fifo_writer #(.PAYLOAD_WORDS(PW), .ADDR_W(3)) dut (
    .rx_clock(clk), .reset(reset), .rx_enable(rx_enable), .rx_strobe(rx_strobe),
    .rx_i(rx_i), .rx_q(rx_q), .timestamp_clock(timestamp_clock), .fifo_space(fifo_space),
    .wrreq(wrreq), .fifodata(fifodata), .pkt_done(pkt_done), .overrun(overrun), .debug(debug)
  );

  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  // Reference model state: samples of the packet being collected.
  bit          model_on = 1'b0;
  bit          m_prev_en, m_sob;
  logic [31:0] m_buf[$];
  logic [31:0] m_ts;
  int          m_pkts;

  typedef struct {
    int          nsamp;
    int          npkts;
    int          nwords;
    logic [31:0] first_hdr;
    int          last_idx;
    logic [31:0] last_hdr;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic emit(input bit eob);
    exp_q.push_back({1'b0, 2'b00, m_sob, eob, 18'd0, 7'(m_buf.size()), 2'b00});
    exp_q.push_back(m_ts);
    foreach (m_buf[k]) exp_q.push_back(m_buf[k]);
    m_buf.delete();
    m_sob = 1'b0;
    m_pkts++;
  endtask

  task automatic model_step();
    bit take, fall, rise;
    take = rx_strobe && (rx_enable || m_prev_en);
    fall = m_prev_en && !rx_enable;
    rise = !m_prev_en && rx_enable;
    if (rise) m_sob = 1'b1;
    if (take) begin
      if (m_buf.size() == 0) m_ts = timestamp_clock;
      m_buf.push_back({rx_q, rx_i});
    end
    if (fall) begin
      if (m_buf.size() == 0) m_ts = timestamp_clock;
      emit(1'b1);
    end else if (m_buf.size() == PW) begin
      emit(1'b0);
    end
    m_prev_en = rx_enable;
  endtask

  task automatic tick();
    if (model_on) model_step();
    @(posedge clk);
    #1;
    timestamp_clock = timestamp_clock + 32'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_enable = 1'b0; rx_strobe = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] i, input logic [15:0] q);
    rx_i = i; rx_q = q; rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("word_count", obs_q.size(), n);
  endtask

  // Output monitor: collects written words and checks each wrreq run is len+2 long.
  initial begin
    int          run_len = 0;
    logic [31:0] run_hdr = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run_len = 0;
      end else begin
        if (wrreq) begin
          obs_q.push_back(fifodata);
          if (run_len == 0) run_hdr = fifodata;
          run_len++;
        end else if (run_len != 0) begin
          chk("burst_len", run_len, {25'd0, run_hdr[8:2]} + 32'd2);
          run_len = 0;
        end
        if (pkt_done) done_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] t1_exp[6];
    logic [31:0] tsf;
    int          d0;

    vecs[0] = '{4, 2,  8, 32'h1000_0010,  6, 32'h0800_0000};
    vecs[1] = '{6, 2, 10, 32'h1000_0010,  6, 32'h0800_0008};
    vecs[2] = '{2, 1,  4, 32'h1800_0008,  0, 32'h1800_0008};
    vecs[3] = '{0, 1,  2, 32'h1800_0000,  0, 32'h1800_0000};
    vecs[4] = '{8, 3, 14, 32'h1000_0010, 12, 32'h0800_0000};
    vecs[5] = '{5, 2,  9, 32'h1000_0010,  6, 32'h0800_0004};
    t1_exp = '{32'h1000_0010, 32'd100, 32'hA001_0001, 32'hA002_0002, 32'hA003_0003, 32'hA004_0004};

    timestamp_clock = 32'd0; fifo_space = 8'd200; rx_i = 16'd0; rx_q = 16'd0;
    reset = 1'b1; rx_enable = 1'b0; rx_strobe = 1'b0;
    repeat (3) tick();
    chk("rst_wrreq", wrreq, 1'b0);
    chk("rst_fifodata", fifodata, 32'd0);
    chk("rst_pkt_done", pkt_done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_debug", debug, 15'd0);
    reset = 1'b0;

    // Single full packet, then a flush with no samples gives a zero-length EOB packet.
    obs_q.delete();
    rx_enable = 1'b1; tick();
    timestamp_clock = 32'd100;
    d0 = done_cnt;
    for (int n = 1; n <= 4; n++) strobe(16'(n), 16'hA000 | 16'(n));
    wait_words(6, 100);
    repeat (3) tick();
    for (int k = 0; k < 6; k++) chk("t1_word", obs_q[k], t1_exp[k]);
    chk("t1_pkt_done", done_cnt - d0, 1);
    tsf = timestamp_clock;
    rx_enable = 1'b0; tick();
    wait_words(8, 100);
    repeat (6) tick();
    chk("t3_hdr", obs_q[6], 32'h0800_0000);
    chk("t3_ts", obs_q[7], tsf);
    chk("t3_no_payload", obs_q.size(), 8);

    // Table of bursts: N samples then enable fall.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      obs_q.delete();
      d0 = done_cnt;
      rx_enable = 1'b1; tick();
      for (int s = 0; s < vecs[v].nsamp; s++) begin
        strobe(16'(s + 1), 16'hD000);
        tick(); tick();
      end
      rx_enable = 1'b0; tick();
      wait_words(vecs[v].nwords, 300);
      repeat (12) tick();
      chk("tab_npkts", done_cnt - d0, vecs[v].npkts);
      chk("tab_nwords", obs_q.size(), vecs[v].nwords);
      chk("tab_first_hdr", obs_q[0], vecs[v].first_hdr);
      chk("tab_last_hdr", obs_q[vecs[v].last_idx], vecs[v].last_hdr);
    end

    // Space threshold: len+1 free words stalls, len+2 releases the header next cycle.
    do_reset();
    obs_q.delete();
    fifo_space = 8'd5;
    rx_enable = 1'b1; tick();
    for (int n = 1; n <= 4; n++) strobe(16'(n), 16'hE000);
    repeat (10) tick();
    chk("t4_stalled_words", obs_q.size(), 0);
    chk("t4_stalled_wrreq", wrreq, 1'b0);
    fifo_space = 8'd6;
    tick();
    chk("t4_wrreq", wrreq, 1'b1);
    chk("t4_hdr", fifodata, 32'h1000_0010);
    repeat (12) tick();

    // Overrun: both banks pending, ninth sample dropped.
    do_reset();
    obs_q.delete();
    fifo_space = 8'd0;
    rx_enable = 1'b1; tick();
    for (int n = 1; n <= 9; n++) strobe(16'(n), 16'hB000 | 16'(n));
    chk("t5_overrun_set", overrun, 1'b1);
    repeat (5) tick();
    chk("t5_no_words", obs_q.size(), 0);
    fifo_space = 8'd200;
    for (int k = 0; k < 20 && !wrreq; k++) tick();
    chk("t5_hdr_seen", wrreq, 1'b1);
    chk("t5_hdr_val", fifodata, 32'h9000_0010);
    chk("t5_overrun_clr", overrun, 1'b0);
    wait_words(12, 100);
    repeat (10) tick();
    chk("t5_hdr2", obs_q[6], 32'h0000_0010);
    chk("t5_last_word", obs_q[11], 32'hB008_0008);
    chk("t5_dropped", obs_q.size(), 12);

    // Reset in the middle of a payload.
    do_reset();
    obs_q.delete();
    rx_enable = 1'b1; tick();
    for (int n = 1; n <= 4; n++) strobe(16'(n), 16'hF000);
    wait_words(3, 50);
    reset = 1'b1; rx_enable = 1'b0;
    tick();
    chk("t6_wrreq", wrreq, 1'b0);
    chk("t6_overrun", overrun, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    obs_q.delete();
    rx_enable = 1'b1; tick();
    timestamp_clock = 32'd5000;
    for (int n = 1; n <= 4; n++) strobe(16'h0010 | 16'(n), 16'hC000 | 16'(n));
    wait_words(6, 100);
    chk("t6_hdr", obs_q[0], 32'h1000_0010);
    chk("t6_ts", obs_q[1], 32'd5000);
    chk("t6_word0", obs_q[2], 32'hC001_0011);
    repeat (6) tick();

    // Randomized bursts against the reference model.
    do_reset();
    obs_q.delete(); exp_q.delete(); m_buf.delete();
    m_prev_en = 1'b0; m_sob = 1'b0; m_pkts = 0;
    d0 = done_cnt;
    model_on = 1'b1;
    for (int b = 0; b < 8; b++) begin
      int  n;
      bit  fall_with;
      rx_strobe = 1'b0;
      rx_enable = 1'b1; tick();
      n = $urandom_range(0, 10);
      fall_with = 1'b0;
      for (int s = 0; s < n; s++) begin
        rx_i = 16'($urandom); rx_q = 16'($urandom); rx_strobe = 1'b1;
        if (s == n - 1 && $urandom_range(0, 2) == 0) begin
          rx_enable = 1'b0;
          fall_with = 1'b1;
        end
        tick();
        rx_strobe = 1'b0;
        if (!fall_with) repeat ($urandom_range(2, 4)) tick();
      end
      if (!fall_with) begin
        rx_enable = 1'b0; tick();
      end
      for (int k = 0; k < 30; k++) begin
        rx_strobe = 1'($urandom_range(0, 1));
        rx_i = 16'($urandom);
        tick();
      end
      rx_strobe = 1'b0;
    end
    wait_words(exp_q.size(), 3000);
    repeat (5) tick();
    model_on = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < obs_q.size()) chk("rand_word", obs_q[k], exp_q[k]);
    end
    chk("rand_npkts", done_cnt - d0, m_pkts);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
